// File: rtl/pacing_scheduler.sv
// pacing_scheduler: merges event arrivals on input_0 and periodic deadlines
// into one in-order task queue and issues one evaluation task at a time.
// Optional macro SCHED_TIMESTAMP_EN: store the push timestamp in each queue
// entry and present it on eval_ts; when undefined eval_ts is tied to 0.
module pacing_scheduler #(
  parameter int DATA_W     = 64,
  parameter int TS_W       = 32,
  parameter int PERIOD_CYC = 1000,
  parameter int DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] input_0,
  input  logic              new_input_0,
  input  logic              eval_done,
  output logic              eval_valid,
  output logic [DATA_W-1:0] eval_data,
  output logic [TS_W-1:0]   eval_ts,
  output logic              pacing_in0,
  output logic              pacing_event,
  output logic              pacing_periodic,
  output logic              q_push,
  output logic              q_pop,
  output logic              q_push_valid,
  output logic              q_pop_valid,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PERIOD_CYC);

  typedef struct packed {
    logic              in_f;
    logic              per_f;
    logic [DATA_W-1:0] data;
`ifdef SCHED_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

  logic [PW-1:0] pcnt_q;
  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [7:0]    drop_q;
  state_t        state_q;
  logic          valid_q, in0_q, per_q;
  logic [DATA_W-1:0] data_q;
  logic [TS_W-1:0]   ts_out_q;
  entry_t        push_e, head;
  logic          tick, full, push_ok, pop, act;

`ifdef SCHED_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp, advances only on enabled cycles
  always_ff @(posedge clk) begin
    if (rst)     ts_q <= '0;
    else if (en) ts_q <= ts_q + 1'b1;
  end
`endif

  // Reset is folded in so every strobe reads 0 while rst is high
  assign act     = en & ~rst;
  assign tick    = act & (pcnt_q == PW'(PERIOD_CYC - 1));
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign q_push  = act & (new_input_0 | tick);
  // Fullness is judged on pre-pop occupancy, so a same-cycle pop never
  // makes room for the push
  assign push_ok = q_push & ~full;
  assign pop     = act & (state_q == IDLE) & (cnt_q != '0);
  assign head    = mem_q[rptr_q];

  assign q_pop        = pop;
  assign q_pop_valid  = pop;
  assign q_push_valid = push_ok;
  assign drop_cnt     = drop_q;

  // Strobes are qualified by en so a frozen ISSUE state emits nothing
  assign eval_valid      = valid_q & act;
  assign pacing_in0      = in0_q & act;
  assign pacing_event    = in0_q & act;
  assign pacing_periodic = per_q & act;
  assign eval_data       = data_q;
  assign eval_ts         = ts_out_q;

  // Assemble the entry; a coincident arrival and tick share one entry
  always_comb begin
    push_e       = '0;
    push_e.in_f  = new_input_0;
    push_e.per_f = tick;
    push_e.data  = new_input_0 ? input_0 : '0;
`ifdef SCHED_TIMESTAMP_EN
    push_e.ts    = ts_q;
`endif
  end

  // Occupancy next-state from accepted push and pop
  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Period counter: 0..PERIOD_CYC-1, tick on the last value
  always_ff @(posedge clk) begin
    if (rst)       pcnt_q <= '0;
    else if (tick) pcnt_q <= '0;
    else if (en)   pcnt_q <= pcnt_q + 1'b1;
  end

  // Queue storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_e;
  end

  // Queue pointers, occupancy and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
      if (q_push && full && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
    end
  end

  // Issue FSM: pop and latch in IDLE, strobe for one cycle, wait for done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      in0_q    <= 1'b0;
      per_q    <= 1'b0;
      data_q   <= '0;
      ts_out_q <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: if (pop) begin
          valid_q <= 1'b1;
          in0_q   <= head.in_f;
          per_q   <= head.per_f;
          data_q  <= head.data;
`ifdef SCHED_TIMESTAMP_EN
          ts_out_q <= head.ts;
`else
          ts_out_q <= '0;
`endif
          state_q <= ISSUE;
        end
        ISSUE: begin
          valid_q <= 1'b0;
          in0_q   <= 1'b0;
          per_q   <= 1'b0;
          state_q <= BUSY;
        end
        BUSY: if (eval_done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pacing_scheduler.sv
// Directed bench for pacing_scheduler: a vector table for a single event
// task plus hand-written sequences for ticks, overflow, en freeze and reset.
module tb_pacing_scheduler;

  logic        clk = 1'b0;
  logic        rst, en, new_input_0, eval_done;
  logic [63:0] input_0;
  logic        eval_valid, pacing_in0, pacing_event, pacing_periodic;
  logic [63:0] eval_data;
  logic [31:0] eval_ts;
  logic        q_push, q_pop, q_push_valid, q_pop_valid;
  logic [7:0]  drop_cnt;

  int tests = 0, fails = 0, ecnt = 0;

  pacing_scheduler #(.DATA_W(64), .TS_W(32), .PERIOD_CYC(1000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .en(en), .input_0(input_0), .new_input_0(new_input_0),
    .eval_done(eval_done), .eval_valid(eval_valid), .eval_data(eval_data),
    .eval_ts(eval_ts), .pacing_in0(pacing_in0), .pacing_event(pacing_event),
    .pacing_periodic(pacing_periodic), .q_push(q_push), .q_pop(q_pop),
    .q_push_valid(q_push_valid), .q_pop_valid(q_pop_valid), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic e, n, dn;
    logic [63:0] d;
    logic xpush, xpv, xpop, xval, xin0, xper;
    logic [63:0] xdata;
    logic [31:0] xts;
  } vec_t;

  function automatic logic [31:0] xts(input logic [31:0] t);
`ifdef SCHED_TIMESTAMP_EN
    return t;
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (enabled cycle %0d): got %0h expected %0h", name, ecnt, act, exp);
    end
  endtask

  // Drive inputs for one cycle and move to the sampling point
  task automatic cyc_begin(input logic e, input logic n, input logic [63:0] d, input logic dn);
    en = e; new_input_0 = n; input_0 = d; eval_done = dn;
    @(negedge clk);
  endtask

  task automatic cyc_end();
    @(posedge clk); #1;
    if (rst) ecnt = 0;
    else if (en) ecnt++;
  endtask

  task automatic idle();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    cyc_end();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_begin(1'b1, 1'b1, 64'd3, 1'b0);
    cyc_begin(1'b1, 1'b1, 64'd3, 1'b0);
    chk("rst q_push", q_push, 0);
    cyc_end();
    rst = 1'b0;
    ecnt = 0;
  endtask

  vec_t tbl [8];
  logic found;

  initial begin
    rst = 1'b1; en = 1'b0; new_input_0 = 1'b0; input_0 = '0; eval_done = 1'b0;
    // Single event at cycle 10, done 3 cycles after issue
    tbl[0] = '{1,0,0, 64'd0, 0,0,0,0,0,0, 64'd0, 32'd0};
    tbl[1] = '{1,1,0, 64'd5, 1,1,0,0,0,0, 64'd0, 32'd0};
    tbl[2] = '{1,0,0, 64'd0, 0,0,1,0,0,0, 64'd0, 32'd0};
    tbl[3] = '{1,0,0, 64'd0, 0,0,0,1,1,0, 64'd5, xts(10)};
    tbl[4] = '{1,0,0, 64'd0, 0,0,0,0,0,0, 64'd5, xts(10)};
    tbl[5] = '{1,0,0, 64'd0, 0,0,0,0,0,0, 64'd5, xts(10)};
    tbl[6] = '{1,0,1, 64'd0, 0,0,0,0,0,0, 64'd5, xts(10)};
    tbl[7] = '{1,0,0, 64'd0, 0,0,0,0,0,0, 64'd5, xts(10)};

    // Reset state
    do_reset();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("reset eval_valid", eval_valid, 0);
    chk("reset eval_data", eval_data, 0);
    chk("reset eval_ts", eval_ts, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    chk("reset q_pop", q_pop, 0);
    cyc_end();

    // First periodic tick at enabled cycle 999
    while (ecnt < 998) idle();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("pre-tick q_push", q_push, 0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("tick q_push", q_push, 1);
    chk("tick q_push_valid", q_push_valid, 1);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("tick q_pop", q_pop, 1);
    chk("tick q_pop_valid", q_pop_valid, 1);
    chk("tick early valid", eval_valid, 0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("tick eval_valid", eval_valid, 1);
    chk("tick periodic", pacing_periodic, 1);
    chk("tick in0", pacing_in0, 0);
    chk("tick data", eval_data, 0);
    chk("tick ts", eval_ts, xts(999));
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("issue one cycle", eval_valid, 0);
    chk("flag cleared", pacing_periodic, 0);
    cyc_end();

    // Table: event task after a fresh reset
    do_reset();
    while (ecnt < 9) idle();
    for (int i = 0; i < 8; i++) begin
      cyc_begin(tbl[i].e, tbl[i].n, tbl[i].d, tbl[i].dn);
      chk($sformatf("v%0d q_push", i), q_push, tbl[i].xpush);
      chk($sformatf("v%0d q_push_valid", i), q_push_valid, tbl[i].xpv);
      chk($sformatf("v%0d q_pop", i), q_pop, tbl[i].xpop);
      chk($sformatf("v%0d eval_valid", i), eval_valid, tbl[i].xval);
      chk($sformatf("v%0d pacing_in0", i), pacing_in0, tbl[i].xin0);
      chk($sformatf("v%0d pacing_event", i), pacing_event, tbl[i].xin0);
      chk($sformatf("v%0d pacing_periodic", i), pacing_periodic, tbl[i].xper);
      chk($sformatf("v%0d eval_data", i), eval_data, tbl[i].xdata);
      chk($sformatf("v%0d eval_ts", i), eval_ts, tbl[i].xts);
      cyc_end();
    end

    // Event coincident with the tick: one entry, both flags
    while (ecnt < 999) idle();
    cyc_begin(1'b1, 1'b1, 64'd7, 1'b0);
    chk("sync q_push", q_push, 1);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("sync single push", q_push, 0);
    chk("sync q_pop", q_pop, 1);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("sync valid", eval_valid, 1);
    chk("sync in0", pacing_in0, 1);
    chk("sync periodic", pacing_periodic, 1);
    chk("sync data", eval_data, 7);
    chk("sync ts", eval_ts, xts(999));
    cyc_end();
    idle();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b1);
    cyc_end();

    // Overflow: six back-to-back events while evaluator stays busy
    for (int k = 1; k <= 6; k++) begin
      cyc_begin(1'b1, 1'b1, 64'(k), 1'b0);
      chk($sformatf("ovf%0d q_push_valid", k), q_push_valid, (k <= 5) ? 1'b1 : 1'b0);
      if (k == 3) begin
        chk("ovf first issue", eval_valid, 1);
        chk("ovf first data", eval_data, 1);
      end
      cyc_end();
    end
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("ovf drop_cnt", drop_cnt, 1);
    cyc_end();
    for (int k = 2; k <= 5; k++) begin
      cyc_begin(1'b1, 1'b0, 64'd0, 1'b1);
      cyc_end();
      found = 1'b0;
      for (int w = 0; w < 8 && !found; w++) begin
        cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
        if (eval_valid) begin
          found = 1'b1;
          chk($sformatf("order data %0d", k), eval_data, 64'(k));
        end
        cyc_end();
      end
      chk($sformatf("order issued %0d", k), found, 1);
    end

    // en=0 freeze during BUSY with input pulses
    for (int i = 0; i < 50; i++) begin
      cyc_begin(1'b0, i[0], 64'd99, 1'b0);
      if (q_push || eval_valid || q_pop || drop_cnt != 8'd1)
        chk($sformatf("freeze cycle %0d", i), {q_push, eval_valid, q_pop, drop_cnt}, 11'd1);
      cyc_end();
    end
    chk("freeze drop_cnt", drop_cnt, 1);
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b1);
    chk("post-freeze q_pop", q_pop, 0);
    cyc_end();
    while (ecnt < 1998) idle();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("delayed tick early", q_push, 0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("delayed tick", q_push, 1);
    cyc_end();
    idle();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("delayed tick valid", eval_valid, 1);
    chk("delayed tick ts", eval_ts, xts(1999));
    cyc_end();

    // Reset mid-BUSY with two queued entries
    cyc_begin(1'b1, 1'b1, 64'd11, 1'b0);
    chk("rst-test push a", q_push_valid, 1);
    cyc_end();
    cyc_begin(1'b1, 1'b1, 64'd12, 1'b0);
    chk("rst-test push b", q_push_valid, 1);
    cyc_end();
    do_reset();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
    chk("post-rst valid", eval_valid, 0);
    chk("post-rst data", eval_data, 0);
    chk("post-rst ts", eval_ts, 0);
    chk("post-rst drop", drop_cnt, 0);
    chk("post-rst q_pop", q_pop, 0);
    chk("post-rst q_push", q_push, 0);
    cyc_end();
    cyc_begin(1'b1, 1'b0, 64'd0, 1'b1);
    chk("stray done q_pop", q_pop, 0);
    cyc_end();
    for (int i = 0; i < 4; i++) begin
      cyc_begin(1'b1, 1'b0, 64'd0, 1'b0);
      chk($sformatf("post-rst quiet %0d", i), {q_pop, eval_valid}, 2'b00);
      cyc_end();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
